regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
// - Shares the register file's single write port (wen/wa/wd/floatingWB) among N_REQ writeback producers (MEM, ALU, FPU).
// - Fixed priority with an age-based anti-starvation override. Output is registered: exactly one write per cycle, 1-cycle latency.
// - Sits between the execute/memory stages and the register file write port; read-side bypass in the register file is unaffected.
// PARAMETERS
// - N_REQ      3   number of requesters; index 0 = highest fixed priority (0=MEM, 1=ALU, 2=FPU)
// - AGE_LIMIT  4   wait cycles, while valid and not granted, after which a requester is starved (1..2^AGE_W-1)
// - AGE_W      3   width of each per-requester age counter
// PORTS
// - reset       in   1          asynchronous, active-low
// - clock       in   1          rising edge
// - stall_wb    in   1          1 = issue no grants this cycle
// - req_valid   in   N_REQ      per-requester write request
// - req_addr    in   5*N_REQ    register index; slice i = [5i+4:5i]
// - req_float   in   N_REQ      1 = FP bank (regs 32..63), 0 = integer bank
// - req_data    in   32*N_REQ   write data; slice i = [32i+31:32i]
// - req_ready   out  N_REQ      one-hot or zero; the request is consumed in a cycle where valid&ready=1
// - wen         out  1          register file write enable (registered)
// - wa          out  5          register file write address (registered)
// - wd          out  32         register file write data (registered)
// - floatingWB  out  1          register file bank select (registered)
// - grant_id    out  2          index of the requester behind the current wen (registered)
// - starved     out  1          1 = last grant was made by the age override (registered; debug/perf)
// BEHAVIOUR
// - Reset: wen=0, wa=0, wd=0, floatingWB=0, grant_id=0, starved=0, all age counters=0. req_ready is combinational and therefore 0 while reset is low.
// - Handshake:
//   - req_valid must not depend on req_ready.
//   - A valid request holds addr/float/data stable until it is consumed.
//   - req_ready is combinational from req_valid, the age counters and stall_wb.
// - Grant selection (combinational, cycle t):
//   - If stall_wb=1, req_ready=0.
//   - Else if any valid requester has age==AGE_LIMIT, grant the lowest such index (starved_next=1).
//   - Else grant the lowest valid index (starved_next=0).
//   - Else grant nothing.
// - Output register (edge ending cycle t), if a grant occurred:
//   - wa, wd, floatingWB take the granted slice; grant_id=index; starved=starved_next.
//   - wen = 1 unless the granted addr==0, in which case wen=0: r0 is suppressed in both banks, but the request is still consumed.
// - With no grant: wen=0; wa, wd, floatingWB, grant_id and starved hold their previous values.
// - Latency: consumed in cycle t, wen=1 during cycle t+1. Back-to-back grants are possible every cycle. wen lasts one cycle per grant.
// - Age counter i, per edge:
//   - Cleared if req_valid[i]=0 or requester i was granted.
//   - Else incremented, saturating at AGE_LIMIT.
//   - While stall_wb=1, counters hold (they do not age).
// - Boundaries:
//   - Several requesters starved at once: lowest index wins; the others keep age==AGE_LIMIT and win in later cycles in index order.
//   - Same register targeted by two requesters in consecutive grants: program order is the producers' responsibility; the arbiter writes in grant order.
//   - stall_wb asserted mid-stream: the grant already registered still produces its wen in the following cycle; nothing new is granted.
//   - Asynchronous reset mid-operation: any pending wen is dropped immediately and all counters clear; un-consumed requests must be re-presented after reset.
// - Width rules: the addr==0 test uses all 5 bits. floatingWB is passed through, never derived from addr.
// STRUCTURE
// - Shared constants in the CPU constants header: REQ_MEM=0, REQ_ALU=1, REQ_FPU=2, WB_N_REQ=3, WB_AGE_LIMIT default.
// - One sub-module, wb_age_counter: a per-requester saturating counter with clear/inc/hold and an "at_limit" output, instantiated N_REQ times.
// - The priority pick and the output register live in this module.
// TESTING
// - Reset: hold reset=0 with all req_valid=1 -> req_ready=000, wen=0; release -> first grant goes to MEM.
// - Single request: ALU writes addr=5, float=0, data=0xDEADBEEF at t -> req_ready=010 at t; at t+1 wen=1, wa=5, wd=0xDEADBEEF, floatingWB=0, grant_id=1.
// - Priority and starvation, AGE_LIMIT=4, MEM and FPU valid continuously:
//   - MEM granted 4 cycles while FPU age climbs to 4.
//   - Cycle 5: FPU granted with starved=1.
//   - Then MEM again.
// - r0 suppression: FPU request with addr=0, float=1 -> req_ready=100, next cycle wen=0; the request is consumed.
// - Stall: stall_wb=1 for 3 cycles with all valid -> no ready, ages hold; on release -> MEM granted.
// - Mid-op reset: grant at t, reset low at t+0.5 -> wen=0 immediately and all counters read 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback-arbiter constants and the registered write-port record.
// Requester indices double as fixed priority: lower index wins.
package regfile_wb_arbiter_pkg;

  localparam int REQ_MEM      = 0;
  localparam int REQ_ALU      = 1;
  localparam int REQ_FPU      = 2;
  localparam int WB_N_REQ     = 3;
  localparam int WB_AGE_LIMIT = 4;
  localparam int WB_AGE_W     = 3;
  localparam int WB_ADDR_W    = 5;
  localparam int WB_DATA_W    = 32;
  localparam int WB_ID_W      = 2;

  typedef struct packed {
    logic                 wen;
    logic [WB_ADDR_W-1:0] wa;
    logic [WB_DATA_W-1:0] wd;
    logic                 floatingWB;
    logic [WB_ID_W-1:0]   grantId;
    logic                 starved;
  } wbWrite_t;

  // r0 is hard-wired in both banks, so a write to it is swallowed
  function automatic logic isZeroAddr(input logic [WB_ADDR_W-1:0] addr);
    return (addr == {WB_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_age_counter.sv
// Per-requester wait counter: holds on stall, clears on idle/grant,
// otherwise counts up and saturates at the starvation limit.
module wb_age_counter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AGE_W     = WB_AGE_W,
  parameter int AGE_LIMIT = WB_AGE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic clear,
  output logic atLimit
);

  localparam logic [AGE_W-1:0] LIMIT_V = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0] ONE_V   = {{(AGE_W-1){1'b0}}, 1'b1};

  logic [AGE_W-1:0] age_r;

  // age register: hold takes precedence over clear so stalls never age or reset waiters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age_r <= {AGE_W{1'b0}};
    end else if (hold) begin
      age_r <= age_r;
    end else if (clear) begin
      age_r <= {AGE_W{1'b0}};
    end else if (age_r != LIMIT_V) begin
      age_r <= age_r + ONE_V;
    end else begin
      age_r <= age_r;
    end
  end

  assign atLimit = (age_r == LIMIT_V);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port among the writeback
// producers: fixed priority with an age override, registered 1-cycle output.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ     = WB_N_REQ,
  parameter int AGE_LIMIT = WB_AGE_LIMIT,
  parameter int AGE_W     = WB_AGE_W
) (
  input  logic                       reset,
  input  logic                       clock,
  input  logic                       stall_wb,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [WB_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]           req_float,
  input  logic [WB_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       wen,
  output logic [WB_ADDR_W-1:0]       wa,
  output logic [WB_DATA_W-1:0]       wd,
  output logic                       floatingWB,
  output logic [WB_ID_W-1:0]         grant_id,
  output logic                       starved
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0]     ageLimit_s;
  logic [N_REQ-1:0]     grantVec_s;
  logic                 starvedHit_s;
  logic [WB_ID_W-1:0]   starvedIdx_s;
  logic [WB_ID_W-1:0]   validIdx_s;
  logic                 grantHit_s;
  logic [WB_ID_W-1:0]   grantIdx_s;
  logic                 starvedNext_s;
  logic [WB_ADDR_W-1:0] selAddr_s;
  wbWrite_t             wbNext_s;
  wbWrite_t             wbOut_r;

  for (genvar g = 0; g < N_REQ; g++) begin : gAge
    wb_age_counter #(
      .AGE_W     (AGE_W),
      .AGE_LIMIT (AGE_LIMIT)
    ) uAge (
      .clock   (clock),
      .reset   (reset),
      .hold    (stall_wb),
      .clear   (~req_valid[g] | grantVec_s[g]),
      .atLimit (ageLimit_s[g])
    );
  end

  // lowest-index scans; walking downwards leaves the lowest hit in place
  always_comb begin
    starvedHit_s = 1'b0;
    starvedIdx_s = {WB_ID_W{1'b0}};
    validIdx_s   = {WB_ID_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && ageLimit_s[i]) begin
        starvedHit_s = 1'b1;
        starvedIdx_s = WB_ID_W'(i);
      end else begin
        starvedIdx_s = starvedIdx_s;
      end
      if (req_valid[i]) begin
        validIdx_s = WB_ID_W'(i);
      end else begin
        validIdx_s = validIdx_s;
      end
    end
  end

  // grant decision plus next value of the write-port register
  always_comb begin
    grantHit_s    = 1'b0;
    grantIdx_s    = {WB_ID_W{1'b0}};
    starvedNext_s = 1'b0;
    if (!reset || stall_wb) begin
      grantHit_s = 1'b0;
    end else if (starvedHit_s) begin
      grantHit_s    = 1'b1;
      grantIdx_s    = starvedIdx_s;
      starvedNext_s = 1'b1;
    end else if (|req_valid) begin
      grantHit_s = 1'b1;
      grantIdx_s = validIdx_s;
    end else begin
      grantHit_s = 1'b0;
    end

    grantVec_s = grantHit_s ? (ONE_HOT0 << grantIdx_s) : {N_REQ{1'b0}};
    selAddr_s  = req_addr[grantIdx_s*WB_ADDR_W +: WB_ADDR_W];

    wbNext_s     = wbOut_r;
    wbNext_s.wen = 1'b0;
    if (grantHit_s) begin
      wbNext_s.wen        = ~isZeroAddr(selAddr_s);
      wbNext_s.wa         = selAddr_s;
      wbNext_s.wd         = req_data[grantIdx_s*WB_DATA_W +: WB_DATA_W];
      wbNext_s.floatingWB = req_float[grantIdx_s];
      wbNext_s.grantId    = grantIdx_s;
      wbNext_s.starved    = starvedNext_s;
    end else begin
      wbNext_s.wen = 1'b0;
    end
  end

  // write-port register; async reset drops any pending write at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wbOut_r <= '0;
    end else begin
      wbOut_r <= wbNext_s;
    end
  end

  assign req_ready  = grantVec_s;
  assign wen        = wbOut_r.wen;
  assign wa         = wbOut_r.wa;
  assign wd         = wbOut_r.wd;
  assign floatingWB = wbOut_r.floatingWB;
  assign grant_id   = wbOut_r.grantId;
  assign starved    = wbOut_r.starved;

endmodule
